// File: rtl/ddr3_pkg.sv
// Shared constants and FSM encoding for the DDR3 write-burst transmitter.
package ddr3_pkg;

  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned DQ_W      = 16;
  localparam int unsigned PRE_CYC   = 2;
  localparam int unsigned IDX_W     = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StPre1,
    StPre2,
    StBurst,
    StPost
  } state_e;

endpackage

// File: rtl/ddr3_burst_serializer.sv
// 8:1 word select for the write burst; data-mask select when DDR3_TX_DM_EN is defined.
module ddr3_burst_serializer
  import ddr3_pkg::*;
(
  input  logic [BURST_LEN*DQ_W-1:0] data_i,
`ifdef DDR3_TX_DM_EN
  input  logic [BURST_LEN-1:0]      mask_i,
  output logic [1:0]                dm_o,
`endif
  input  logic [IDX_W-1:0]          idx_i,
  output logic [DQ_W-1:0]           word_o
);

  logic [DQ_W-1:0] words [BURST_LEN];

  always_comb begin
    for (int k = 0; k < BURST_LEN; k++) begin
      words[k] = data_i[k*DQ_W +: DQ_W];
    end
  end

  assign word_o = words[idx_i];

`ifdef DDR3_TX_DM_EN
  assign dm_o = {2{mask_i[idx_i]}};
`endif

endmodule

// File: rtl/ddr3_write_burst_tx.sv
// DDR3 write-burst transmitter: two-cycle preamble, 8-word DDR burst, one-cycle postamble.
// Optional data mask enabled with DDR3_TX_DM_EN.
module ddr3_write_burst_tx
  import ddr3_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BURST_LEN*DQ_W-1:0] din,
`ifdef DDR3_TX_DM_EN
  input  logic [BURST_LEN-1:0]      mask,
`endif
  output logic [DQ_W-1:0]           dq,
  output logic                      strobe,
  output logic                      dq_oe,
  output logic                      strobe_oe,
  output logic                      listen,
  output logic                      busy,
  output logic                      done
`ifdef DDR3_TX_DM_EN
  ,
  output logic [1:0]                dm
`endif
);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [BURST_LEN*DQ_W-1:0] data_q, data_d;

  logic [DQ_W-1:0] dq_q, dq_d;
  logic            strobe_q, strobe_d;
  logic            oe_q, oe_d;
  logic            listen_q, listen_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DQ_W-1:0] ser_word;

`ifdef DDR3_TX_DM_EN
  logic [BURST_LEN-1:0] mask_q, mask_d;
  logic [1:0]           dm_q, dm_d;
  logic [1:0]           ser_dm;
`endif

  ddr3_burst_serializer u_serializer (
    .data_i (data_q),
`ifdef DDR3_TX_DM_EN
    .mask_i (mask_q),
    .dm_o   (ser_dm),
`endif
    .idx_i  (idx_d),
    .word_o (ser_word)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef DDR3_TX_DM_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPre1;
          data_d  = din;
`ifdef DDR3_TX_DM_EN
          mask_d  = mask;
`endif
        end
      end
      StPre1: state_d = StPre2;
      StPre2: begin
        state_d = StBurst;
        idx_d   = '0;
      end
      StBurst: begin
        if (idx_q == IDX_W'(BURST_LEN - 1)) begin
          state_d = StPost;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StPost:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so each register shows the value for
  // the cycle it is entering, keeping every output a flop with no input-to-output path.
  always_comb begin
    dq_d     = '0;
    strobe_d = 1'b0;
    oe_d     = (state_d != StIdle);
    listen_d = (state_d == StPre2);
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StPost);
`ifdef DDR3_TX_DM_EN
    dm_d     = '0;
`endif
    if (state_d == StBurst) begin
      dq_d     = ser_word;
      strobe_d = ~idx_d[0];
`ifdef DDR3_TX_DM_EN
      dm_d     = ser_dm;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      data_q   <= '0;
      dq_q     <= '0;
      strobe_q <= 1'b0;
      oe_q     <= 1'b0;
      listen_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DDR3_TX_DM_EN
      mask_q   <= '0;
      dm_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      dq_q     <= dq_d;
      strobe_q <= strobe_d;
      oe_q     <= oe_d;
      listen_q <= listen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DDR3_TX_DM_EN
      mask_q   <= mask_d;
      dm_q     <= dm_d;
`endif
    end
  end

  assign dq        = dq_q;
  assign strobe    = strobe_q;
  assign dq_oe     = oe_q;
  assign strobe_oe = oe_q;
  assign listen    = listen_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DDR3_TX_DM_EN
  assign dm        = dm_q;
`endif

endmodule

// File: tb/tb_ddr3_write_burst_tx.sv
// Bench for ddr3_write_burst_tx: directed scenarios plus random traffic against a
// cycle-offset reference model; dm is checked when DDR3_TX_DM_EN is defined.
module tb_ddr3_write_burst_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] din;
  logic [7:0]   mask;
  logic [15:0]  dq;
  logic         strobe, dq_oe, strobe_oe, listen, busy, done;
  logic [1:0]   dm;

  always #5 clk = ~clk;

  ddr3_write_burst_tx dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
`ifdef DDR3_TX_DM_EN
    .mask      (mask),
`endif
    .dq        (dq),
    .strobe    (strobe),
    .dq_oe     (dq_oe),
    .strobe_oe (strobe_oe),
    .listen    (listen),
    .busy      (busy),
    .done      (done)
`ifdef DDR3_TX_DM_EN
    ,
    .dm        (dm)
`endif
  );

`ifndef DDR3_TX_DM_EN
  assign dm = 2'b00;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a burst accepted at cycle t0 occupies cycles t0+1..t0+11.
  int           cyc = 0;
  int           t0 = 0;
  bit           active = 1'b0;
  logic [127:0] m_din = '0;
  logic [7:0]   m_mask = '0;

  // Far-end capture buffer, armed by listen, filled on the following 8 strobe edges.
  bit           cap_armed = 1'b0;
  int           cap_wptr = 0;
  logic [15:0]  cap_buf [8];
  logic [127:0] cap_exp = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit s, input bit r, input logic [127:0] d, input logic [7:0] m);
    int          off;
    int          k;
    logic [15:0] e_dq;
    logic [1:0]  e_dm;
    bit          e_str, e_oe, e_lis, e_busy, e_done;
    @(negedge clk);
    off    = active ? cyc - t0 : 0;
    e_dq   = '0;
    e_dm   = '0;
    e_str  = 1'b0;
    e_lis  = (off == 2);
    e_done = (off == 11);
    e_oe   = (off >= 1 && off <= 11);
    e_busy = e_oe;
    if (off >= 3 && off <= 10) begin
      k     = off - 3;
      e_dq  = m_din[k*16 +: 16];
      e_str = (k % 2 == 0);
`ifdef DDR3_TX_DM_EN
      e_dm  = m_mask[k] ? 2'b11 : 2'b00;
`endif
    end
    check_eq("dq", 32'(dq), 32'(e_dq));
    check_eq("strobe", 32'(strobe), 32'(e_str));
    check_eq("dq_oe", 32'(dq_oe), 32'(e_oe));
    check_eq("strobe_oe", 32'(strobe_oe), 32'(e_oe));
    check_eq("listen", 32'(listen), 32'(e_lis));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("dm", 32'(dm), 32'(e_dm));

    if (cap_armed && cap_wptr < 8) begin
      cap_buf[cap_wptr] = dq;
      cap_wptr++;
      if (cap_wptr == 8) begin
        for (int i = 0; i < 8; i++) check_eq("loopback", 32'(cap_buf[i]), 32'(cap_exp[i*16 +: 16]));
        cap_armed = 1'b0;
      end
    end
    if (listen === 1'b1) begin
      cap_armed = 1'b1;
      cap_wptr  = 0;
      cap_exp   = m_din;
    end

    start = s;
    reset = r;
    din   = d;
    mask  = m;

    if (r) begin
      active    = 1'b0;
      cap_armed = 1'b0;
    end else if (s && !(active && off >= 1 && off <= 11)) begin
      active = 1'b1;
      t0     = cyc;
      m_din  = d;
      m_mask = m;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 128'h0, 8'h00);
  endtask

  logic [127:0] w_a, w_b;

  initial begin
    start = 1'b0;
    reset = 1'b1;
    din   = '0;
    mask  = '0;
    for (int k = 0; k < 8; k++) begin
      w_a[k*16 +: 16] = 16'((k + 1) * 16'h1111);
      w_b[k*16 +: 16] = 16'hA000 + 16'(k);
    end
    @(posedge clk);
    step(1'b0, 1'b1, 128'h0, 8'h00);
    step(1'b0, 1'b0, 128'h0, 8'h00);

    // Single burst with loopback capture and mask 0000_0101.
    step(1'b1, 1'b0, w_a, 8'b0000_0101);
    idle(14);

    // Start while busy at T+5 is ignored.
    step(1'b1, 1'b0, w_a, 8'h00);
    idle(4);
    step(1'b1, 1'b0, w_b, 8'hFF);
    idle(9);

    // Back-to-back: second start at T+12.
    step(1'b1, 1'b0, w_b, 8'h81);
    idle(11);
    step(1'b1, 1'b0, w_a, 8'h3C);
    idle(13);

    // Reset at T+6, then a fresh start.
    step(1'b1, 1'b0, w_a, 8'hAA);
    idle(5);
    step(1'b0, 1'b1, 128'h0, 8'h00);
    step(1'b1, 1'b0, w_b, 8'h55);
    idle(13);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0),
           {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
    end
    idle(13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
